// File: rtl/adc_acq_sequencer.sv
// ---------------------------------------------------------------------------
// adc_acq_sequencer
//
// Per-channel acquisition sequencer. On an accepted fill trigger it steps the
// ADC data/header mux through: one fill header, then for every waveform a
// waveform header followed by a fixed number of 8-sample data bursts, an
// optional idle gap between waveforms, and finally one checksum word. The
// DDR3 write FIFO strobe is the OR of the mux selects delayed by one cycle so
// it lines up with the mux's registered output.
//
// Ports
//   clk                   acquisition clock (single domain)
//   reset                 asynchronous, active-high reset
//   trigger               single-cycle fill start pulse
//   adc_dat_valid         a new 8-sample burst is on the mux inputs this cycle
//   num_waveforms         waveforms per fill        (sampled on accepted trigger)
//   waveform_length       bursts per waveform       (sampled on accepted trigger)
//   waveform_gap          idle cycles between wfms  (sampled on accepted trigger)
//   fifo_prog_full        DDR3 write FIFO programmable-full flag
//   select_fill_hdr       mux select: fill header
//   select_waveform_hdr   mux select: waveform header
//   select_dat            mux select: ADC data
//   select_checksum       mux select: checksum
//   checksum_update       mux: XOR the current data into the checksum
//   current_waveform_num  zero-based index of the current waveform
//   num_fill_bursts       num_waveforms * waveform_length, latched on trigger
//   fifo_wr_en            FIFO write strobe (selects delayed one cycle)
//   busy                  state is not IDLE
//   fill_done             one-cycle pulse after the checksum is written
//   cfg_err               one-cycle pulse: trigger rejected, bad configuration
//   trig_lost             one-cycle pulse: trigger arrived while busy
//   overflow_err          sticky: a FIFO write happened while prog_full was set
// ---------------------------------------------------------------------------
module adc_acq_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic        adc_dat_valid,
    input  logic [11:0] num_waveforms,
    input  logic [22:0] waveform_length,
    input  logic [21:0] waveform_gap,
    input  logic        fifo_prog_full,
    output logic        select_fill_hdr,
    output logic        select_waveform_hdr,
    output logic        select_dat,
    output logic        select_checksum,
    output logic        checksum_update,
    output logic [11:0] current_waveform_num,
    output logic [22:0] num_fill_bursts,
    output logic        fifo_wr_en,
    output logic        busy,
    output logic        fill_done,
    output logic        cfg_err,
    output logic        trig_lost,
    output logic        overflow_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL_HDR,
        S_WFM_HDR,
        S_DATA,
        S_GAP,
        S_CHECKSUM
    } state_t;

    state_t      state_q, state_d;

    // Configuration captured when a trigger is accepted
    logic [11:0] nwfm_q, nwfm_d;
    logic [22:0] wlen_q, wlen_d;
    logic [21:0] gap_q, gap_d;
    logic [22:0] fill_bursts_q, fill_bursts_d;

    // Progress counters
    logic [11:0] wfm_cnt_q, wfm_cnt_d;
    logic [22:0] burst_cnt_q, burst_cnt_d;
    logic [21:0] gap_cnt_q, gap_cnt_d;

    // Status
    logic        cfg_err_q, cfg_err_d;
    logic        trig_lost_q, trig_lost_d;
    logic        overflow_q, overflow_d;
    logic        wr_en_q;
    logic        fill_done_q;

    // Trigger qualification
    logic [34:0] product;
    logic        cfg_bad;
    logic        last_burst;
    logic        last_wfm;
    logic        any_select;

    // Full-width product so an oversized fill is detected rather than wrapped
    assign product    = 35'(num_waveforms) * 35'(waveform_length);
    assign cfg_bad    = (num_waveforms == 12'd0) || (waveform_length == 23'd0)
                        || (product[34:23] != 12'd0);
    assign last_burst = (burst_cnt_q == (wlen_q - 23'd1));
    assign last_wfm   = (wfm_cnt_q == (nwfm_q - 12'd1));

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            nwfm_q        <= '0;
            wlen_q        <= '0;
            gap_q         <= '0;
            fill_bursts_q <= '0;
            wfm_cnt_q     <= '0;
            burst_cnt_q   <= '0;
            gap_cnt_q     <= '0;
            cfg_err_q     <= 1'b0;
            trig_lost_q   <= 1'b0;
            overflow_q    <= 1'b0;
            wr_en_q       <= 1'b0;
            fill_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            nwfm_q        <= nwfm_d;
            wlen_q        <= wlen_d;
            gap_q         <= gap_d;
            fill_bursts_q <= fill_bursts_d;
            wfm_cnt_q     <= wfm_cnt_d;
            burst_cnt_q   <= burst_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            cfg_err_q     <= cfg_err_d;
            trig_lost_q   <= trig_lost_d;
            overflow_q    <= overflow_d;
            // The mux registers its output, so the FIFO strobe trails the
            // select by exactly one cycle.
            wr_en_q       <= any_select;
            // The checksum word leaves the mux the cycle after CHECKSUM.
            fill_done_q   <= (state_q == S_CHECKSUM);
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        nwfm_d        = nwfm_q;
        wlen_d        = wlen_q;
        gap_d         = gap_q;
        fill_bursts_d = fill_bursts_q;
        wfm_cnt_d     = wfm_cnt_q;
        burst_cnt_d   = burst_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        cfg_err_d     = 1'b0;
        // Any non-IDLE state (including the CHECKSUM cycle) drops a trigger.
        trig_lost_d   = trigger && (state_q != S_IDLE);
        // Writes are never stalled; a write into a nearly full FIFO is only
        // flagged.
        overflow_d    = overflow_q | (wr_en_q & fifo_prog_full);

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        nwfm_d        = num_waveforms;
                        wlen_d        = waveform_length;
                        gap_d         = waveform_gap;
                        fill_bursts_d = product[22:0];
                        overflow_d    = 1'b0;
                        wfm_cnt_d     = '0;
                        burst_cnt_d   = '0;
                        gap_cnt_d     = '0;
                        state_d       = S_FILL_HDR;
                    end
                end
            end

            S_FILL_HDR: state_d = S_WFM_HDR;

            S_WFM_HDR: state_d = S_DATA;

            S_DATA: begin
                if (adc_dat_valid) begin
                    if (last_burst) begin
                        burst_cnt_d = '0;
                        if (last_wfm) begin
                            state_d = S_CHECKSUM;
                        end else if (gap_q == 22'd0) begin
                            wfm_cnt_d = wfm_cnt_q + 12'd1;
                            state_d   = S_WFM_HDR;
                        end else begin
                            // First GAP cycle is counted as cycle 1.
                            gap_cnt_d = 22'd1;
                            state_d   = S_GAP;
                        end
                    end else begin
                        burst_cnt_d = burst_cnt_q + 23'd1;
                    end
                end
            end

            S_GAP: begin
                if (gap_cnt_q == gap_q) begin
                    wfm_cnt_d   = wfm_cnt_q + 12'd1;
                    burst_cnt_d = '0;
                    state_d     = S_WFM_HDR;
                end else begin
                    gap_cnt_d = gap_cnt_q + 22'd1;
                end
            end

            S_CHECKSUM: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs. Header/checksum selects decode the registered state; the data
    // select must coincide with the burst on the mux inputs, so it is gated
    // by adc_dat_valid in the same cycle. Only one state is active at a
    // time, so at most one select is ever high.
    // -----------------------------------------------------------------------
    assign select_fill_hdr      = (state_q == S_FILL_HDR);
    assign select_waveform_hdr  = (state_q == S_WFM_HDR);
    assign select_dat           = (state_q == S_DATA) && adc_dat_valid;
    assign select_checksum      = (state_q == S_CHECKSUM);
    assign checksum_update      = select_dat;
    assign any_select           = select_fill_hdr | select_waveform_hdr
                                  | select_dat | select_checksum;

    assign busy                 = (state_q != S_IDLE);
    assign current_waveform_num = wfm_cnt_q;
    assign num_fill_bursts      = fill_bursts_q;
    assign fifo_wr_en           = wr_en_q;
    assign fill_done            = fill_done_q;
    assign cfg_err              = cfg_err_q;
    assign trig_lost            = trig_lost_q;
    assign overflow_err         = overflow_q;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adc_acq_sequencer
//
// Directed testbench for adc_acq_sequencer. Inputs change on the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
// Select codes in traces: 0 none, 1 fill hdr, 2 wfm hdr, 3 data,
// 4 checksum, 9 more than one select high.
// ---------------------------------------------------------------------------
module tb_adc_acq_sequencer;

    logic        clk;
    logic        reset;
    logic        trigger;
    logic        adc_dat_valid;
    logic [11:0] num_waveforms;
    logic [22:0] waveform_length;
    logic [21:0] waveform_gap;
    logic        fifo_prog_full;
    logic        select_fill_hdr;
    logic        select_waveform_hdr;
    logic        select_dat;
    logic        select_checksum;
    logic        checksum_update;
    logic [11:0] current_waveform_num;
    logic [22:0] num_fill_bursts;
    logic        fifo_wr_en;
    logic        busy;
    logic        fill_done;
    logic        cfg_err;
    logic        trig_lost;
    logic        overflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-cycle trace buffers
    int          code_t [64];
    logic        wr_t   [64];
    logic        done_t [64];
    logic        busy_t [64];
    logic        sd_t   [64];
    logic        cu_t   [64];
    logic        tl_t   [64];
    logic        ovf_t  [64];
    logic        v_t    [64];
    logic [11:0] wfm_t  [64];

    adc_acq_sequencer dut (
        .clk                  (clk),
        .reset                (reset),
        .trigger              (trigger),
        .adc_dat_valid        (adc_dat_valid),
        .num_waveforms        (num_waveforms),
        .waveform_length      (waveform_length),
        .waveform_gap         (waveform_gap),
        .fifo_prog_full       (fifo_prog_full),
        .select_fill_hdr      (select_fill_hdr),
        .select_waveform_hdr  (select_waveform_hdr),
        .select_dat           (select_dat),
        .select_checksum      (select_checksum),
        .checksum_update      (checksum_update),
        .current_waveform_num (current_waveform_num),
        .num_fill_bursts      (num_fill_bursts),
        .fifo_wr_en           (fifo_wr_en),
        .busy                 (busy),
        .fill_done            (fill_done),
        .cfg_err              (cfg_err),
        .trig_lost            (trig_lost),
        .overflow_err         (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sel_code();
        int n;
        n = int'(select_fill_hdr) + int'(select_waveform_hdr)
            + int'(select_dat) + int'(select_checksum);
        if (n > 1)               return 9;
        if (select_fill_hdr)     return 1;
        if (select_waveform_hdr) return 2;
        if (select_dat)          return 3;
        if (select_checksum)     return 4;
        return 0;
    endfunction

    function automatic logic [45:0] outs_vec();
        return {select_fill_hdr, select_waveform_hdr, select_dat, select_checksum,
                checksum_update, current_waveform_num, num_fill_bursts, fifo_wr_en,
                busy, fill_done, cfg_err, trig_lost, overflow_err};
    endfunction

    // Drives masks cycle by cycle and records the outputs (no comparisons).
    task automatic run_trace(input int ncyc, input logic [63:0] trig_m,
                             input logic [63:0] val_m, input logic [63:0] pf_m);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            trigger        = trig_m[c];
            adc_dat_valid  = val_m[c];
            fifo_prog_full = pf_m[c];
            #1;
            code_t[c] = sel_code();
            wr_t[c]   = fifo_wr_en;
            done_t[c] = fill_done;
            busy_t[c] = busy;
            sd_t[c]   = select_dat;
            cu_t[c]   = checksum_update;
            tl_t[c]   = trig_lost;
            ovf_t[c]  = overflow_err;
            v_t[c]    = adc_dat_valid;
            wfm_t[c]  = current_waveform_num;
        end
        trigger        = 1'b0;
        adc_dat_valid  = 1'b0;
        fifo_prog_full = 1'b0;
    endtask

    task automatic set_cfg(input logic [11:0] n, input logic [22:0] l, input logic [21:0] g);
        num_waveforms   = n;
        waveform_length = l;
        waveform_gap    = g;
    endtask

    task automatic test_reset();
        logic [45:0] o;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        o = outs_vec();
        n_checks++;
        if (o !== 46'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", o);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        o = outs_vec();
        n_checks++;
        if (o !== 46'd0) begin
            n_fail++;
            $display("FAIL after_reset_idle: got %h expected 0", o);
        end
        $display("test_reset: done");
    endtask

    task automatic test_basic_fill();
        int exp_code[17] = '{0,1,2,3,3,3,0,0,0,0,2,3,3,3,4,0,0};
        int nwr;
        logic e;
        set_cfg(12'd2, 23'd3, 22'd4);
        run_trace(17, 64'h1, '1, 64'h0);
        nwr = 0;
        for (int c = 0; c < 17; c++) begin
            n_checks++;
            if (code_t[c] !== exp_code[c]) begin
                n_fail++;
                $display("FAIL basic_sel[%0d]: got %0d expected %0d", c, code_t[c], exp_code[c]);
            end
            e = (c > 0) ? (exp_code[c-1] != 0) : 1'b0;
            n_checks++;
            if (wr_t[c] !== e) begin
                n_fail++;
                $display("FAIL basic_wr[%0d]: got %b expected %b", c, wr_t[c], e);
            end
            e = (c == 15);
            n_checks++;
            if (done_t[c] !== e) begin
                n_fail++;
                $display("FAIL basic_done[%0d]: got %b expected %b", c, done_t[c], e);
            end
            e = (c >= 1) && (c <= 14);
            n_checks++;
            if (busy_t[c] !== e) begin
                n_fail++;
                $display("FAIL basic_busy[%0d]: got %b expected %b", c, busy_t[c], e);
            end
            if (c >= 1 && c <= 14) begin
                n_checks++;
                if (wfm_t[c] !== ((c >= 10) ? 12'd1 : 12'd0)) begin
                    n_fail++;
                    $display("FAIL basic_wfm[%0d]: got %0d expected %0d", c, wfm_t[c], (c >= 10) ? 1 : 0);
                end
            end
            if (wr_t[c] === 1'b1) nwr++;
        end
        n_checks++;
        if (nwr !== 10) begin
            n_fail++;
            $display("FAIL basic_wr_count: got %0d expected 10", nwr);
        end
        n_checks++;
        if (num_fill_bursts !== 23'd6) begin
            n_fail++;
            $display("FAIL basic_num_fill_bursts: got %0d expected 6", num_fill_bursts);
        end
        $display("test_basic_fill: N=2 L=3 G=4 done");
    endtask

    task automatic test_gapped_valid();
        int nsd;
        int ncu;
        set_cfg(12'd1, 23'd4, 22'd0);
        run_trace(13, 64'h1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0);
        nsd = 0;
        ncu = 0;
        for (int c = 0; c < 13; c++) begin
            if (sd_t[c] === 1'b1) nsd++;
            if (cu_t[c] === 1'b1) ncu++;
        end
        for (int c = 3; c <= 9; c++) begin
            n_checks++;
            if (sd_t[c] !== v_t[c] || cu_t[c] !== v_t[c]) begin
                n_fail++;
                $display("FAIL gapped_dat[%0d]: got sel=%b upd=%b expected %b", c, sd_t[c], cu_t[c], v_t[c]);
            end
        end
        n_checks++;
        if (nsd !== 4 || ncu !== 4) begin
            n_fail++;
            $display("FAIL gapped_counts: got sel=%0d upd=%0d expected 4", nsd, ncu);
        end
        n_checks++;
        if (code_t[10] !== 4) begin
            n_fail++;
            $display("FAIL gapped_checksum: got %0d expected 4", code_t[10]);
        end
        n_checks++;
        if (done_t[11] !== 1'b1) begin
            n_fail++;
            $display("FAIL gapped_done: got %b expected 1", done_t[11]);
        end
        $display("test_gapped_valid: N=1 L=4 done");
    endtask

    task automatic test_config_rejects();
        // N = 0
        set_cfg(12'd0, 23'd5, 22'd0);
        @(negedge clk); trigger = 1'b1;
        @(negedge clk); trigger = 1'b0; #1;
        n_checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reject_n0: got cfg_err=%b busy=%b expected 1 0", cfg_err, busy);
        end
        @(negedge clk); #1;
        n_checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reject_n0_pulse: got cfg_err=%b busy=%b expected 0 0", cfg_err, busy);
        end
        // 4095 * 2^22 does not fit in 23 bits
        set_cfg(12'd4095, 23'h40_0000, 22'd0);
        @(negedge clk); trigger = 1'b1;
        @(negedge clk); trigger = 1'b0; #1;
        n_checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reject_overflow: got cfg_err=%b busy=%b expected 1 0", cfg_err, busy);
        end
        // 2048 * 4095 = 8386560 fits
        set_cfg(12'd2048, 23'd4095, 22'd0);
        @(negedge clk); trigger = 1'b1;
        @(negedge clk); trigger = 1'b0; #1;
        n_checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b1 || select_fill_hdr !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_large: got cfg_err=%b busy=%b fh=%b expected 0 1 1", cfg_err, busy, select_fill_hdr);
        end
        n_checks++;
        if (num_fill_bursts !== 23'd8386560) begin
            n_fail++;
            $display("FAIL accept_large_bursts: got %0d expected 8386560", num_fill_bursts);
        end
        // Abandon the long fill
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("test_config_rejects: done");
    endtask

    task automatic test_trig_during_fill();
        int exp_code[17] = '{0,1,2,3,3,3,4,0,0,1,2,3,3,3,4,0,0};
        logic e;
        set_cfg(12'd1, 23'd3, 22'd0);
        run_trace(17, 64'h151, '1, 64'h0);
        for (int c = 0; c < 17; c++) begin
            n_checks++;
            if (code_t[c] !== exp_code[c]) begin
                n_fail++;
                $display("FAIL trig_sel[%0d]: got %0d expected %0d", c, code_t[c], exp_code[c]);
            end
            e = (c == 5) || (c == 7);
            n_checks++;
            if (tl_t[c] !== e) begin
                n_fail++;
                $display("FAIL trig_lost[%0d]: got %b expected %b", c, tl_t[c], e);
            end
            e = (c == 7) || (c == 15);
            n_checks++;
            if (done_t[c] !== e) begin
                n_fail++;
                $display("FAIL trig_done[%0d]: got %b expected %b", c, done_t[c], e);
            end
        end
        $display("test_trig_during_fill: done");
    endtask

    task automatic test_fifo_full();
        logic e;
        set_cfg(12'd1, 23'd3, 22'd0);
        run_trace(9, 64'h1, '1, 64'h8);
        n_checks++;
        if (wr_t[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL full_wr3: got %b expected 1", wr_t[3]);
        end
        for (int c = 0; c < 9; c++) begin
            e = (c >= 4);
            n_checks++;
            if (ovf_t[c] !== e) begin
                n_fail++;
                $display("FAIL full_overflow[%0d]: got %b expected %b", c, ovf_t[c], e);
            end
        end
        $display("test_fifo_full: done");
    endtask

    task automatic test_zero_gap();
        int exp_code[11] = '{0,1,2,3,2,3,2,3,4,0,0};
        logic [11:0] exp_wfm[11] = '{0,0,0,0,1,1,2,2,2,2,2};
        int nwr;
        set_cfg(12'd3, 23'd1, 22'd0);
        run_trace(11, 64'h1, '1, 64'h0);
        n_checks++;
        if (ovf_t[0] !== 1'b1 || ovf_t[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_gap_ovf_clear: got %b,%b expected 1,0", ovf_t[0], ovf_t[1]);
        end
        nwr = 0;
        for (int c = 0; c < 11; c++) begin
            n_checks++;
            if (code_t[c] !== exp_code[c]) begin
                n_fail++;
                $display("FAIL zero_gap_sel[%0d]: got %0d expected %0d", c, code_t[c], exp_code[c]);
            end
            if (c >= 2 && c <= 8) begin
                n_checks++;
                if (wfm_t[c] !== exp_wfm[c]) begin
                    n_fail++;
                    $display("FAIL zero_gap_wfm[%0d]: got %0d expected %0d", c, wfm_t[c], exp_wfm[c]);
                end
            end
            if (wr_t[c] === 1'b1) nwr++;
        end
        n_checks++;
        if (nwr !== 8 || done_t[9] !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_gap_end: got writes=%0d done=%b expected 8 1", nwr, done_t[9]);
        end
        $display("test_zero_gap: N=3 L=1 G=0 done");
    endtask

    task automatic test_reset_mid_fill();
        logic [45:0] o;
        int ndone;
        int nbusy;
        set_cfg(12'd2, 23'd1, 22'd5);
        run_trace(6, 64'h1, '1, 64'h0);
        n_checks++;
        if (busy_t[5] !== 1'b1 || code_t[5] !== 0 || wfm_t[5] !== 12'd0) begin
            n_fail++;
            $display("FAIL mid_in_gap: got busy=%b sel=%0d expected 1 0", busy_t[5], code_t[5]);
        end
        adc_dat_valid = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        o = outs_vec();
        n_checks++;
        if (o !== 46'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h expected 0", o);
        end
        @(negedge clk);
        reset = 1'b0;
        run_trace(12, 64'h0, '1, 64'h0);
        ndone = 0;
        nbusy = 0;
        for (int c = 0; c < 12; c++) begin
            if (done_t[c] === 1'b1) ndone++;
            if (busy_t[c] === 1'b1) nbusy++;
        end
        n_checks++;
        if (ndone !== 0 || nbusy !== 0) begin
            n_fail++;
            $display("FAIL mid_abandoned: got done=%0d busy=%0d expected 0 0", ndone, nbusy);
        end
        set_cfg(12'd2, 23'd1, 22'd0);
        run_trace(10, 64'h1, '1, 64'h0);
        n_checks++;
        if (code_t[1] !== 1 || wfm_t[2] !== 12'd0 || wfm_t[4] !== 12'd1) begin
            n_fail++;
            $display("FAIL mid_restart: got sel=%0d wfm=%0d,%0d expected 1 0,1", code_t[1], wfm_t[2], wfm_t[4]);
        end
        n_checks++;
        if (code_t[6] !== 4 || done_t[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_restart_end: got sel=%0d done=%b expected 4 1", code_t[6], done_t[7]);
        end
        $display("test_reset_mid_fill: done");
    endtask

    initial begin
        reset          = 1'b1;
        trigger        = 1'b0;
        adc_dat_valid  = 1'b0;
        fifo_prog_full = 1'b0;
        set_cfg(12'd0, 23'd0, 22'd0);
        test_reset();
        test_basic_fill();
        test_gapped_valid();
        test_config_rejects();
        test_trig_during_fill();
        test_fifo_full();
        test_zero_gap();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
